// File: rtl/fp10_pkg.sv
// Shared FP10 format constants: sign[9] exp[8:4] man[3:0], bias 15.
package fp10_pkg;
    localparam int N    = 10;
    localparam int E    = 5;
    localparam int MA   = 4;
    localparam int BIAS = 15;

    localparam int SIGN_BIT = 9;
    localparam int EXP_MSB  = 8;
    localparam int EXP_LSB  = 4;
    localparam int MAN_MSB  = 3;
    localparam int MAN_LSB  = 0;

    localparam int PROD_W = 2 * (MA + 1);
endpackage

// File: rtl/fp10_mul_core.sv
// Combinational FP10 multiply: hidden-bit product, one-step normalise, G/R/sticky
// round-up, modulo-32 exponent. No special-value handling of any kind.
module fp10_mul_core
    import fp10_pkg::*;
(
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] prod_n;
    logic              sticky;
    logic              nrm;
    logic              rnd_up;
    logic [MA-1:0]     man;
    logic [E-1:0]      exp_sum;

    always_comb begin
        prod   = PROD_W'({1'b1, a[MAN_MSB:MAN_LSB]}) * PROD_W'({1'b1, b[MAN_MSB:MAN_LSB]});
        // Sticky is taken from the raw product, before the normalising shift.
        sticky = |prod[2:0];
        nrm    = prod[PROD_W-1];
        prod_n = nrm ? prod : (prod << 1);
        rnd_up = prod_n[4] & (prod_n[3] | sticky);
        man    = prod_n[8:5] + {{(MA-1){1'b0}}, rnd_up};
        exp_sum = a[EXP_MSB:EXP_LSB] + b[EXP_MSB:EXP_LSB] - E'(BIAS) + {{(E-1){1'b0}}, nrm};
        y      = {a[SIGN_BIT] ^ b[SIGN_BIT], exp_sum, man};
    end
endmodule

// File: rtl/fp10_mul_arbiter.sv
// Round-robin arbiter sharing one FP10 multiplier between NREQ requesters,
// behind a two-stage pipeline (S1 operands, S2 result) with an op counter.
module fp10_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int N    = fp10_pkg::N
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*N-1:0]        req_a,
    input  logic [NREQ*N-1:0]        req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [N-1:0]             rsp_y,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [15:0]              op_count
);
    localparam int IW = $clog2(NREQ);

    // Handshake: a transfer happens on an edge where valid && ready are both 1.
    // Producers hold data stable while valid; req_ready is a function of
    // req_valid, pipeline occupancy, rsp_ready and rst only, never of operands.
    logic          v1_q, v1_d, v2_q, v2_d;
    logic [N-1:0]  a1_q, a1_d, b1_q, b1_d, y2_q, y2_d;
    logic [IW-1:0] id1_q, id1_d, id2_q, id2_d, ptr_q, ptr_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [IW-1:0] win, cand;
    logic [N-1:0]  a_sel, b_sel, core_y;
    logic          found, gnt, advance1, advance2;

    fp10_mul_core u_core (
        .a (a1_q),
        .b (b1_q),
        .y (core_y)
    );

    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        cand  = ptr_q;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(ptr_q) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        advance2  = !v2_q || rsp_ready;
        advance1  = !v1_q || advance2;
        gnt       = found && advance1 && !rst;
        req_ready = gnt ? (NREQ'(1) << win) : '0;
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IW'(i)) begin
                a_sel = req_a[i*N +: N];
                b_sel = req_b[i*N +: N];
            end
        end
    end

    always_comb begin
        v1_d  = v1_q;
        a1_d  = a1_q;
        b1_d  = b1_q;
        id1_d = id1_q;
        v2_d  = v2_q;
        y2_d  = y2_q;
        id2_d = id2_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (advance2) begin
            v2_d  = v1_q;
            y2_d  = core_y;
            id2_d = id1_q;
        end
        if (advance1) begin
            v1_d = gnt;
        end
        if (gnt) begin
            a1_d  = a_sel;
            b1_d  = b_sel;
            id1_d = win;
            ptr_d = win;
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            a1_q  <= '0;
            b1_q  <= '0;
            id1_q <= '0;
            v2_q  <= 1'b0;
            y2_q  <= '0;
            id2_q <= '0;
            // Reset pointer to the last index so requester 0 is searched first.
            ptr_q <= IW'(NREQ - 1);
            cnt_q <= '0;
        end else begin
            v1_q  <= v1_d;
            a1_q  <= a1_d;
            b1_q  <= b1_d;
            id1_q <= id1_d;
            v2_q  <= v2_d;
            y2_q  <= y2_d;
            id2_q <= id2_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    assign rsp_valid = v2_q;
    assign rsp_y     = y2_q;
    assign rsp_id    = id2_q;
    assign op_count  = cnt_q;
endmodule

// File: tb/tb_fp10_mul_arbiter.sv
// Bench for fp10_mul_arbiter: directed cases plus random traffic, checked against
// an occupancy/round-robin reference and an arithmetic FP10 product model.
module tb_fp10_mul_arbiter;
    localparam int NREQ = 4;
    localparam int N    = 10;
    localparam int IW   = 2;
    localparam int W    = IW + N;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [N-1:0]      rsp_y;
    logic [IW-1:0]     rsp_id;
    logic [15:0]       op_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0]    exp_q[$];
    int              m_ptr = NREQ - 1;
    int              m_cnt = 0;
    int              inflight = 0;
    int              grant_total = 0;
    int              rsp_total = 0;
    logic [NREQ-1:0] gnt_seen = '0;
    logic            hold_vld = 1'b0;
    logic [N-1:0]    hold_y = '0;
    logic [IW-1:0]   hold_id = '0;

    fp10_mul_arbiter #(.NREQ(NREQ), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id),
        .op_count  (op_count)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, expv, $time);
        end
    endtask

    // FP10 product from the format rules, using integer arithmetic.
    function automatic logic [N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        int p, keep, g, r, st, man, ex, s;
        p  = (16 + int'(a[3:0])) * (16 + int'(b[3:0]));
        st = ((p % 8) != 0) ? 1 : 0;
        ex = int'(a[8:4]) + int'(b[8:4]) - 15;
        if (p >= 512) begin
            keep = p / 32;
            g    = (p / 16) % 2;
            r    = (p / 8) % 2;
            ex   = ex + 1;
        end else begin
            keep = p / 16;
            g    = (p / 8) % 2;
            r    = (p / 4) % 2;
        end
        man = (keep + ((g == 1 && (r == 1 || st == 1)) ? 1 : 0)) % 16;
        ex  = (ex + 64) % 32;
        s   = int'(a[9] ^ b[9]);
        return {s[0], ex[4:0], man[3:0]};
    endfunction

    // Reference: pipeline occupancy (capacity 2) + round-robin order + FIFO of results.
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_gnt;
        logic [W-1:0]    item;
        int              win;
        bit              can;
        exp_gnt = '0;
        win     = -1;
        if (rst) begin
            chk("rst_ready", 32'(req_ready), 32'(0));
            exp_q.delete();
            inflight = 0;
            m_ptr    = NREQ - 1;
            m_cnt    = 0;
            hold_vld = 1'b0;
            gnt_seen = '0;
        end else begin
            if (hold_vld) begin
                chk("stall_valid", 32'(rsp_valid), 32'(1));
                chk("stall_y", 32'(rsp_y), 32'(hold_y));
                chk("stall_id", 32'(rsp_id), 32'(hold_id));
            end
            chk("op_count", 32'(op_count), 32'(m_cnt));
            can = (inflight < 2) || (rsp_ready == 1'b1);
            if (can) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (win < 0 && req_valid[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
                end
            end
            if (win >= 0) exp_gnt[win] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_gnt));
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_extra", 32'(rsp_valid), 32'(0));
                end else begin
                    item = exp_q.pop_front();
                    chk("rsp_y", 32'(rsp_y), 32'(item[N-1:0]));
                    chk("rsp_id", 32'(rsp_id), 32'(item[W-1:N]));
                    inflight--;
                    rsp_total++;
                end
            end
            hold_vld = rsp_valid && !rsp_ready;
            hold_y   = rsp_y;
            hold_id  = rsp_id;
            if (win >= 0) begin
                item = {2'(win), ref_mul(req_a[win*N +: N], req_b[win*N +: N])};
                exp_q.push_back(item);
                inflight++;
                grant_total++;
                m_ptr = win;
                m_cnt = (m_cnt + 1) % 65536;
            end
            gnt_seen = req_ready;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("reset_op_count", 32'(op_count), 32'(0));
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
    endtask

    task automatic drain();
        @(posedge clk);
        #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        chk("drain_empty", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic run_single(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                              input logic [N-1:0] y);
        bit got;
        @(posedge clk);
        #1;
        rsp_ready         = 1'b1;
        req_valid         = '0;
        req_valid[i]      = 1'b1;
        req_a[i*N +: N]   = a;
        req_b[i*N +: N]   = b;
        got = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1'b1;
        end
        chk("single_grant", 32'(got), 32'(1));
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        chk("single_lat1_valid", 32'(rsp_valid), 32'(0));
        @(posedge clk);
        @(negedge clk);
        chk("single_valid", 32'(rsp_valid), 32'(1));
        chk("single_y", 32'(rsp_y), 32'(y));
        chk("single_id", 32'(rsp_id), 32'(i));
    endtask

    task automatic run_contention();
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*N +: N] = N'($urandom);
            req_b[i*N +: N] = N'($urandom);
        end
        req_valid = '1;
        for (int g = 0; g < 8; g++) begin
            @(negedge clk);
            chk("contention_grant", 32'(req_ready), 32'(1) << (g % NREQ));
            @(posedge clk);
            #1;
            req_a[(g % NREQ)*N +: N] = N'($urandom);
            req_b[(g % NREQ)*N +: N] = N'($urandom);
        end
        @(negedge clk);
        chk("contention_count", 32'(op_count), 32'(8));
        drain();
    endtask

    task automatic run_backpressure();
        int g0, r0;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_a[i*N +: N] = N'($urandom);
            req_b[i*N +: N] = N'($urandom);
        end
        req_valid = 4'b0111;
        g0 = grant_total;
        repeat (5) @(posedge clk);
        #1;
        chk("bp_in_flight", 32'(grant_total - g0), 32'(2));
        r0 = rsp_total;
        drain();
        chk("bp_delivered", 32'(rsp_total - r0), 32'(2));
    endtask

    task automatic run_mid_reset();
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        req_valid = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_pre_valid", 32'(rsp_valid), 32'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("mid_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("mid_op_count", 32'(op_count), 32'(0));
        chk("mid_first_grant", 32'(req_ready), 32'(1));
        drain();
    endtask

    task automatic random_phase(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (gnt_seen[i] || !req_valid[i]) begin
                    req_valid[i]    = ($urandom_range(0, 99) < 55);
                    req_a[i*N +: N] = N'($urandom);
                    req_b[i*N +: N] = N'($urandom);
                end
            end
            rsp_ready = ($urandom_range(0, 99) < 65);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        do_reset();
        run_single(0, 10'h0F8, 10'h0F8, 10'h102);
        run_single(1, 10'h0F0, 10'h0F0, 10'h0F0);
        run_single(2, 10'h2F8, 10'h0F0, 10'h2F8);
        run_single(3, 10'h0F3, 10'h0F3, 10'h0F7);
        run_single(0, 10'h0FF, 10'h0FF, 10'h10E);
        run_contention();
        run_backpressure();
        run_mid_reset();
        random_phase(600);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
